// File: rtl/rtc_bus_pkg.sv
// Shared types and default timing for the RTC multiplexed-bus burst controller.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    GAP,
    DATA_STROBE,
    DATA_HOLD,
    NEXT
  } state_e;

  localparam int T_AS_DEF  = 4;
  localparam int T_AH_DEF  = 2;
  localparam int T_GAP_DEF = 8;
  localparam int T_DS_DEF  = 4;
  localparam int T_DH_DEF  = 3;

  // RTC strobes are active-low; this is their inactive level.
  localparam logic STROBE_IDLE = 1'b1;

endpackage

// File: rtl/phase_timer.sv
// Down-counter timing one bus phase; expire marks the last cycle of the phase.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // len is phase length minus one, so the loaded value counts down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = len;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Every timed phase reloads on entry, so no reset is needed here.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/rtc_burst_rw.sv
// Burst read/write sequencer for the RTC multiplexed address/data bus.
module rtc_burst_rw
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 4,
  parameter int T_AS   = T_AS_DEF,
  parameter int T_AH   = T_AH_DEF,
  parameter int T_GAP  = T_GAP_DEF,
  parameter int T_DS   = T_DS_DEF,
  parameter int T_DH   = T_DH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  inout  wire  [DATA_W-1:0] add_data_rtc,
  output logic              a_d_s,
  output logic              cs_s,
  output logic              rd_s,
  output logic              wr_s
);

  localparam logic [CNT_W-1:0] LD_AS  = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] LD_AH  = CNT_W'(T_AH - 1);
  localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LD_DS  = CNT_W'(T_DS - 1);
  localparam logic [CNT_W-1:0] LD_DH  = CNT_W'(T_DH - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_byte_q, wr_byte_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_len;
  logic              tmr_expire;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_out;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .load   (tmr_load),
    .len    (tmr_len),
    .expire (tmr_expire)
  );

  // Next-state, counters and data capture; the timer is loaded on entry to each timed phase.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wr_en_d    = wr_en_q;
    wr_byte_d  = wr_byte_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_len    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = burst_len;
          wr_en_d = wr_en;
          // An empty burst goes straight to NEXT to produce its done pulse.
          state_d = (burst_len == '0) ? NEXT : ADDR_SETUP;
        end
      end
      ADDR_SETUP: begin
        state_d  = ADDR_STROBE;
        tmr_load = 1'b1;
        tmr_len  = LD_AS;
      end
      ADDR_STROBE: begin
        if (tmr_expire) begin
          state_d  = ADDR_HOLD;
          tmr_load = 1'b1;
          tmr_len  = LD_AH;
        end
      end
      ADDR_HOLD: begin
        if (tmr_expire) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_len  = LD_GAP;
        end
      end
      GAP: begin
        if (tmr_expire) begin
          if (wr_en_q)
            wr_byte_d = wr_data;
          state_d  = DATA_STROBE;
          tmr_load = 1'b1;
          tmr_len  = LD_DS;
        end
      end
      DATA_STROBE: begin
        if (tmr_expire) begin
          // Capture while rd_s is still low so the RTC is still driving.
          if (!wr_en_q) begin
            rd_data_d  = add_data_rtc;
            rd_valid_d = 1'b1;
          end
          state_d  = DATA_HOLD;
          tmr_load = 1'b1;
          tmr_len  = LD_DH;
        end
      end
      DATA_HOLD: begin
        if (tmr_expire)
          state_d = NEXT;
      end
      NEXT: begin
        addr_d = addr_q + DATA_W'(1);
        if (rem_q != '0)
          rem_d = rem_q - LEN_W'(1);
        state_d = (rem_q > LEN_W'(1)) ? ADDR_SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin strobes, bus drive and status decoded purely from registered state.
  always_comb begin
    a_d_s       = STROBE_IDLE;
    cs_s        = STROBE_IDLE;
    rd_s        = STROBE_IDLE;
    wr_s        = STROBE_IDLE;
    bus_oe      = 1'b0;
    bus_out     = addr_q;
    busy        = (state_q != IDLE);
    done        = (state_q == NEXT) && (rem_q <= LEN_W'(1));
    wr_data_req = (state_q == GAP) && tmr_expire && wr_en_q;
    case (state_q)
      ADDR_SETUP: a_d_s = 1'b0;
      ADDR_STROBE: begin
        a_d_s  = 1'b0;
        cs_s   = 1'b0;
        wr_s   = 1'b0;
        bus_oe = 1'b1;
      end
      ADDR_HOLD: begin
        a_d_s  = 1'b0;
        bus_oe = 1'b1;
      end
      DATA_STROBE: begin
        cs_s    = 1'b0;
        rd_s    = wr_en_q;
        wr_s    = !wr_en_q;
        bus_oe  = wr_en_q;
        bus_out = wr_byte_q;
      end
      DATA_HOLD: begin
        bus_oe  = wr_en_q;
        bus_out = wr_byte_q;
      end
      default: ;
    endcase
  end

  assign add_data_rtc = bus_oe ? bus_out : {DATA_W{1'bz}};
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;

  // Control and read-result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      wr_en_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      wr_en_q    <= wr_en_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Address and write byte are only consumed under valid state, so they carry no reset.
  always_ff @(posedge clk) begin
    addr_q    <= addr_d;
    wr_byte_q <= wr_byte_d;
  end

endmodule

// File: doc/rtc_burst_rw.md
# rtc_burst_rw

Parametrised controller for the RTC's multiplexed address/data bus (A/D, CS, RD, WR plus shared 8-bit AD lines). It sequences one or more back-to-back register reads or writes from a single start request. Addresses auto-increment, and every bus phase duration is set by a parameter. It sits between the register/scheduler logic and the RTC pins, replacing single-access sequencing with burst transfers and explicit data handshakes.

## Interface
- DATA_W, 8, width of AD bus, addresses and data
- LEN_W, 4, width of burst_len
- CNT_W, 4, width of phase timer; every T_* must be in 1..2^CNT_W
- T_AS, 4, address strobe cycles (CS/WR low, address driven)
- T_AH, 2, address hold cycles after strobe release
- T_GAP, 8, idle cycles between address and data phase
- T_DS, 4, data strobe cycles (CS and RD or WR low)
- T_DH, 3, data hold cycles after strobe release
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- wr_en  in  1  1 = write burst, 0 = read burst; latched with start
- base_addr  in  DATA_W  first register address; latched with start
- burst_len  in  LEN_W  number of registers; latched with start
- wr_data  in  DATA_W  write byte; sampled on the edge ending a wr_data_req cycle
- wr_data_req  out  1  one-cycle pulse requesting the next write byte
- rd_data  out  DATA_W  last byte read; holds until next capture
- rd_valid  out  1  one-cycle pulse, rd_data updated
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of burst
- add_data_rtc  inout  DATA_W  RTC AD bus; high-Z when not driving
- a_d_s, cs_s, rd_s, wr_s  out  1 each  RTC strobes, active-low

## Operation
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- States: IDLE → ADDR_SETUP (1 cycle, a_d_s=0) → ADDR_STROBE (T_AS, cs_s=wr_s=0, bus=addr) → ADDR_HOLD (T_AH, strobes high, bus=addr) → GAP (T_GAP, a_d_s=1, bus high-Z) → DATA_STROBE (T_DS, cs_s=0 plus rd_s=0 on read or wr_s=0 on write) → DATA_HOLD (T_DH) → NEXT (1 cycle).
- Write data:
  - Bus drives the latched write byte during DATA_STROBE and DATA_HOLD.
  - wr_data_req is high in the last GAP cycle; the byte is latched on that edge.
  - The source must present wr_data combinationally in that cycle.
- Read data:
  - rd_data is captured on the edge ending the last DATA_STROBE cycle, while rd_s is still low.
  - rd_valid is high the following cycle.
- NEXT:
  - Decrements the remaining count and sets addr = addr+1 mod 2^DATA_W (0xFF wraps to 0x00).
  - If remaining ≠ 0 → ADDR_SETUP.
  - Otherwise done=1 and → IDLE.
- burst_len=0: no bus activity; busy=1 and done=1 in the cycle after start, then IDLE.
- start while busy is ignored. wr_en, base_addr and burst_len changing mid-burst have no effect.
- Reset values: a_d_s=cs_s=rd_s=wr_s=1, bus high-Z, busy=done=rd_valid=wr_data_req=0, rd_data=0, state IDLE.
- Reset mid-burst: next edge forces the reset values and IDLE. No done pulse.

## Timing
- Cycle 0 = start high in IDLE. Default per-register sequence:
  - cycle 1: ADDR_SETUP
  - cycles 2–5: ADDR_STROBE
  - cycles 6–7: ADDR_HOLD
  - cycles 8–15: GAP (wr_data_req in cycle 15)
  - cycles 16–19: DATA_STROBE
  - cycles 20–22: DATA_HOLD (rd_valid in cycle 20)
  - cycle 23: NEXT
- Per-register length = T_AS+T_AH+T_GAP+T_DS+T_DH+2 (23 with defaults). The burst length is N times that.
- busy is high from cycle 1 through the done cycle inclusive, and low the next cycle. A new start is accepted in that cycle.

## Structure
- Package rtc_bus_pkg holds:
  - the state enum
  - default timing constants (T_* values above)
  - the strobe idle level constant
- One sub-module, phase_timer (CNT_W), with ports load, len, and expire (expire = last cycle of phase).
- The main FSM owns the address counter, the remaining counter and the data registers.

## Test plan
- Single read, base_addr=0x23, burst_len=1, RTC model returns 0x59:
  - a_d_s low cycles 1–7.
  - cs_s/wr_s low cycles 2–5 with bus=0x23.
  - rd_s low cycles 16–19.
  - rd_valid=1 and rd_data=0x59 in cycle 20.
  - done in cycle 23.
- Single write, addr 0x21, wr_data=0x45 shown at wr_data_req (cycle 15):
  - wr_s low cycles 16–19 with bus=0x45, held through cycle 22.
  - RTC model register 0x21 = 0x45.
- Burst read, base_addr=0xFE, burst_len=3: addresses 0xFE, 0xFF, 0x00 on the bus; three rd_valid pulses; single done at cycle 69.
- start pulsed in cycle 10 of an active burst: ignored; exactly one done.
- reset asserted in cycle 17 (DATA_STROBE): cycle 18 all strobes high, bus high-Z, busy=0, no done or rd_valid.
- burst_len=0: done and busy in cycle 1 only; strobes never leave 1.
